demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream.sv | 128 ++++++++++++
 tb/tb_demux_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - packet-locked 1:2 stream demux with one registered beat per output channel
module demux_stream #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             select_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] a_data_o,
    output logic             a_valid_o,
    output logic             a_last_o,
    input  logic             a_ready_i,
    output logic [WIDTH-1:0] b_data_o,
    output logic             b_valid_o,
    output logic             b_last_o,
    input  logic             b_ready_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT_A = 2'd1,
        PKT_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic             a_valid_q, a_valid_d;
    logic             a_last_q, a_last_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             b_valid_q, b_valid_d;
    logic             b_last_q, b_last_d;

    logic target_b;
    logic a_free;
    logic b_free;
    logic accept;
    logic load_a;
    logic load_b;

    // Select only matters at a packet boundary; mid-packet the channel is locked.
    always_comb begin
        target_b = 1'b0;
        case (state_q)
            IDLE:    target_b = select_i;
            PKT_A:   target_b = 1'b0;
            PKT_B:   target_b = 1'b1;
            default: target_b = 1'b0;
        endcase
    end

    assign a_free     = !a_valid_q || a_ready_i;
    assign b_free     = !b_valid_q || b_ready_i;
    assign in_ready_o = rst_n_i && (target_b ? b_free : a_free);
    assign accept     = in_valid_i && in_ready_o;
    assign load_a     = accept && !target_b;
    assign load_b     = accept && target_b;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_last_i) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = target_b ? PKT_B : PKT_A;
            end
        end
    end

    // A load wins over a drain in the same cycle so the slot stays full.
    always_comb begin
        a_data_d  = a_data_q;
        a_last_d  = a_last_q;
        a_valid_d = a_valid_q;
        if (load_a) begin
            a_data_d  = in_data_i;
            a_last_d  = in_last_i;
            a_valid_d = 1'b1;
        end else if (a_valid_q && a_ready_i) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        b_data_d  = b_data_q;
        b_last_d  = b_last_q;
        b_valid_d = b_valid_q;
        if (load_b) begin
            b_data_d  = in_data_i;
            b_last_d  = in_last_i;
            b_valid_d = 1'b1;
        end else if (b_valid_q && b_ready_i) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            a_data_q  <= '0;
            a_last_q  <= 1'b0;
            a_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_data_q  <= a_data_d;
            a_last_q  <= a_last_d;
            a_valid_q <= a_valid_d;
            b_data_q  <= b_data_d;
            b_last_q  <= b_last_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign a_data_o  = a_data_q;
    assign a_last_o  = a_last_q;
    assign a_valid_o = a_valid_q;
    assign b_data_o  = b_data_q;
    assign b_last_o  = b_last_q;
    assign b_valid_o = b_valid_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - vector table, reset corner and random scoreboard checks for demux_stream
module tb_demux_stream;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_last;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_last;
    logic         b_ready;
    logic         busy;

    int tests = 0;
    int fails = 0;

    demux_stream #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .select_i   (sel),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready),
        .a_data_o   (a_data),
        .a_valid_o  (a_valid),
        .a_last_o   (a_last),
        .a_ready_i  (a_ready),
        .b_data_o   (b_data),
        .b_valid_o  (b_valid),
        .b_last_o   (b_last),
        .b_ready_i  (b_ready),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Reference: each channel is a FIFO of beats still owed to its sink (at most one
    // sits in the output slot); lock_ch is the channel an open packet is bound to.
    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    int    lock_ch = -1;
    int    accepted = 0;
    logic  rdy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " a_valid"}, a_valid, qa.size() != 0);
        check({tag, " b_valid"}, b_valid, qb.size() != 0);
        check({tag, " busy"}, busy, lock_ch != -1);
        if (qa.size() != 0) begin
            check({tag, " a_data"}, a_data, qa[0].d);
            check({tag, " a_last"}, a_last, qa[0].l);
        end
        if (qb.size() != 0) begin
            check({tag, " b_data"}, b_data, qb[0].d);
            check({tag, " b_last"}, b_last, qb[0].l);
        end
    endtask

    function automatic void model_reset();
        qa.delete();
        qb.delete();
        lock_ch = -1;
    endfunction

    // Entered between edges; applies inputs, checks, then advances one rising edge.
    task automatic step(input logic s, input logic [W-1:0] d, input logic v, input logic l,
                        input logic ar, input logic br, input string tag);
        int    tgt;
        logic  exp_rdy;
        logic  acc;
        beat_t nb;
        sel = s; in_data = d; in_valid = v; in_last = l; a_ready = ar; b_ready = br;
        #2;
        tgt     = (lock_ch == -1) ? int'(s) : lock_ch;
        exp_rdy = (tgt == 0) ? (qa.size() == 0 || ar) : (qb.size() == 0 || br);
        rdy_seen = in_ready;
        check({tag, " in_ready"}, in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (qa.size() != 0 && ar) void'(qa.pop_front());
        if (qb.size() != 0 && br) void'(qb.pop_front());
        if (acc) begin
            nb.d = d;
            nb.l = l;
            if (tgt == 0) qa.push_back(nb);
            else          qb.push_back(nb);
            lock_ch = l ? -1 : tgt;
            accepted++;
        end
        #1;
        check_outputs(tag);
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] d;
        logic         v, l, ar, br;
        logic         rdy;
        logic         av;
        logic [W-1:0] ad;
        logic         bv;
        logic [W-1:0] bd;
        logic         bsy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // sel d v l ar br | rdy av ad bv bd busy
        tbl[0]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1};
        tbl[3]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};

        rst_n = 1'b0; sel = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset a_valid", a_valid, 1'b0);
        check("reset b_valid", b_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset a_data", a_data, 2'd0);
        check("reset b_last", b_last, 1'b0);
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].ar, tbl[i].br,
                 $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl in_ready", i), rdy_seen, tbl[i].rdy);
            check($sformatf("vec%0d tbl a_valid", i), a_valid, tbl[i].av);
            check($sformatf("vec%0d tbl b_valid", i), b_valid, tbl[i].bv);
            check($sformatf("vec%0d tbl busy", i), busy, tbl[i].bsy);
            if (tbl[i].av) check($sformatf("vec%0d tbl a_data", i), a_data, tbl[i].ad);
            if (tbl[i].bv) check($sformatf("vec%0d tbl b_data", i), b_data, tbl[i].bd);
        end

        // Reset while a B packet is open and B holds a stalled beat.
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, "rst_setup");
        check("rst_setup b_valid", b_valid, 1'b1);
        check("rst_setup busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst b_valid", b_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst in_ready", in_ready, 1'b0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
        check("post_rst a_data", a_data, 2'd2);
        check("post_rst b_valid", b_valid, 1'b0);

        // Random traffic against the queue model.
        accepted = 0;
        for (int c = 0; c < 6000 && accepted < 1000; c++) begin
            step($urandom_range(0, 1), W'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 6), "rand");
        end
        check("rand beats accepted", accepted >= 1000, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "drain");
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, "drain");
        check("drain a_valid", a_valid, 1'b0);
        check("drain b_valid", b_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
